nibble_cmp_seq: RTL and testbench

//  Sequences one external 4-bit cascadable magnitude comparator to compare two WIDTH-bit operands.

---
 rtl/nibble_cmp_seq.sv | 146 ++++++++++++++
 tb/tb_nibble_cmp_seq.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/nibble_cmp_seq.sv
// nibble_cmp_seq: drives one external 4-bit cascadable magnitude comparator
// nibble by nibble (LSB first) to compare two WIDTH-bit operands, with an
// optional signed mode for the RV32I branch-condition path.
module nibble_cmp_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             is_signed,
    output logic             busy,
    output logic             done,
    output logic             res_eq,
    output logic             res_lt,
    output logic             res_gt,
    output logic [3:0]       cmp_a,
    output logic [3:0]       cmp_b,
    output logic             cmp_ieq,
    output logic             cmp_ilt,
    output logic             cmp_ibt,
    input  logic             cmp_oeq,
    input  logic             cmp_olt,
    input  logic             cmp_obt
);

    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = $clog2(NIB);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [2:0]       flags_q, flags_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             signed_q, signed_d;
    logic             res_eq_q, res_eq_d;
    logic             res_lt_q, res_lt_d;
    logic             res_gt_q, res_gt_d;

    logic             last_nib;
    logic [3:0]       nib_a, nib_b;

    assign last_nib = (idx_q == IDXW'(NIB - 1));

    // Next-state logic: accept start from IDLE/DONE, walk nibbles in RUN.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        flags_d  = flags_q;
        a_d      = a_q;
        b_d      = b_q;
        signed_d = signed_q;
        res_eq_d = res_eq_q;
        res_lt_d = res_lt_q;
        res_gt_d = res_gt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    state_d  = S_RUN;
                    a_d      = op_a;
                    b_d      = op_b;
                    signed_d = is_signed;
                    idx_d    = '0;
                    flags_d  = 3'b100;
                end
            end
            S_RUN: begin
                flags_d = {cmp_oeq, cmp_olt, cmp_obt};
                if (last_nib) begin
                    state_d  = S_DONE;
                    res_eq_d = cmp_oeq;
                    res_lt_d = cmp_olt;
                    res_gt_d = cmp_obt;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            flags_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            res_eq_q <= 1'b0;
            res_lt_q <= 1'b0;
            res_gt_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            flags_q  <= flags_d;
            a_q      <= a_d;
            b_q      <= b_d;
            signed_q <= signed_d;
            res_eq_q <= res_eq_d;
            res_lt_q <= res_lt_d;
            res_gt_q <= res_gt_d;
        end
    end

    // Comparator drive: current nibble pair, sign bit flipped on the top
    // nibble in signed mode, all zero outside RUN.
    always_comb begin
        nib_a   = '0;
        nib_b   = '0;
        cmp_a   = '0;
        cmp_b   = '0;
        cmp_ieq = 1'b0;
        cmp_ilt = 1'b0;
        cmp_ibt = 1'b0;
        for (int unsigned i = 0; i < NIB; i++) begin
            if (idx_q == IDXW'(i)) begin
                nib_a = a_q[4*i +: 4];
                nib_b = b_q[4*i +: 4];
            end
        end
        if (state_q == S_RUN) begin
            cmp_a = nib_a;
            cmp_b = nib_b;
            if (signed_q && last_nib) begin
                cmp_a[3] = ~nib_a[3];
                cmp_b[3] = ~nib_b[3];
            end
            {cmp_ieq, cmp_ilt, cmp_ibt} = flags_q;
        end
    end

    assign busy   = (state_q == S_RUN);
    assign done   = (state_q == S_DONE);
    assign res_eq = res_eq_q;
    assign res_lt = res_lt_q;
    assign res_gt = res_gt_q;

endmodule

// File: tb/tb_nibble_cmp_seq.sv
// Directed bench for nibble_cmp_seq; models the external 4-bit cascadable
// comparator and checks results, latency, busy-ignore, back-to-back, reset.
module tb_nibble_cmp_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] op_a, op_b;
    logic        is_signed;
    logic        busy, done, res_eq, res_lt, res_gt;
    logic [3:0]  cmp_a, cmp_b;
    logic        cmp_ieq, cmp_ilt, cmp_ibt;
    logic        cmp_oeq, cmp_olt, cmp_obt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nibble_cmp_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start),
        .op_a(op_a), .op_b(op_b), .is_signed(is_signed),
        .busy(busy), .done(done),
        .res_eq(res_eq), .res_lt(res_lt), .res_gt(res_gt),
        .cmp_a(cmp_a), .cmp_b(cmp_b),
        .cmp_ieq(cmp_ieq), .cmp_ilt(cmp_ilt), .cmp_ibt(cmp_ibt),
        .cmp_oeq(cmp_oeq), .cmp_olt(cmp_olt), .cmp_obt(cmp_obt)
    );

    // External comparator: magnitude decides, equal nibbles pass the cascade.
    always_comb begin
        if (cmp_a > cmp_b)      {cmp_oeq, cmp_olt, cmp_obt} = 3'b001;
        else if (cmp_a < cmp_b) {cmp_oeq, cmp_olt, cmp_obt} = 3'b010;
        else                    {cmp_oeq, cmp_olt, cmp_obt} = {cmp_ieq, cmp_ilt, cmp_ibt};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one compare and wait for done; lat counts edges including the
    // one that samples start.
    task automatic run_cmp(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input logic [2:0] exp_res, input string tag);
        int lat;
        @(negedge clk);
        op_a = a; op_b = b; is_signed = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, lat, 32'd9);
        check({tag, "_res"}, {29'd0, res_eq, res_lt, res_gt}, {29'd0, exp_res});
        @(posedge clk); #1;
        check({tag, "_done1cyc"}, {31'd0, done}, 32'd0);
        check({tag, "_hold"}, {29'd0, res_eq, res_lt, res_gt}, {29'd0, exp_res});
    endtask

    initial begin
        int n, dones;
        rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; is_signed = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", {26'd0, busy, done, res_eq, res_lt, res_gt, cmp_ieq},
              32'd0);
        check("rst_cmp", {24'd0, cmp_a, cmp_b}, 32'd0);
        @(negedge clk); rst = 1'b0;

        // T1..T3
        run_cmp(32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 3'b100, "t1_eq");
        run_cmp(32'h00000001, 32'hFFFFFFFF, 1'b0, 3'b010, "t2_uns");
        run_cmp(32'h00000001, 32'hFFFFFFFF, 1'b1, 3'b001, "t2_sgn");
        run_cmp(32'h80000005, 32'h80000004, 1'b1, 3'b001, "t3_low");
        run_cmp(32'h7FFFFFFF, 32'h80000000, 1'b1, 3'b001, "t3_top");
        run_cmp(32'h12345678, 32'h12345679, 1'b0, 3'b010, "lt_low");
        check("idle_cmp", {21'd0, cmp_a, cmp_b, cmp_ieq, cmp_ilt, cmp_ibt}, 32'd0);

        // T4: start pulse during RUN cycle 3 must be ignored
        @(negedge clk);
        op_a = 32'h00000001; op_b = 32'h00000002; is_signed = 1'b0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        op_a = 32'h00000005; op_b = 32'h00000001; start = 1'b1;
        @(negedge clk); start = 1'b0;
        dones = 0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("t4_dones", dones, 32'd1);
        check("t4_res", {29'd0, res_eq, res_lt, res_gt}, 32'b010);

        // T5: start held through DONE -> immediate restart
        @(negedge clk);
        op_a = 32'hCAFEF00D; op_b = 32'hCAFEF00D; is_signed = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        n = 1;
        while (!done && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("t5_first_res", {29'd0, res_eq, res_lt, res_gt}, 32'b100);
        op_a = 32'h00000002; op_b = 32'h00000001;
        @(posedge clk); #1;
        start = 1'b0;
        check("t5_busy_next", {31'd0, busy}, 32'd1);
        n = 1;
        while (!done && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("t5_gap", n, 32'd9);
        check("t5_second_res", {29'd0, res_eq, res_lt, res_gt}, 32'b001);

        // T6: reset at RUN cycle 4 discards the operation
        @(negedge clk);
        op_a = 32'h00000003; op_b = 32'h00000009; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("t6_rst", {29'd0, busy, done, res_eq | res_lt | res_gt}, 32'd0);
        @(negedge clk); rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            if (done || busy) dones++;
        end
        check("t6_quiet", dones, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
